// File: rtl/led_seq_ctrl_pkg.sv
// led_ctrl_defs: mode encodings, LED start patterns and
// small helpers shared by the LED sequencer and its bench.
package led_ctrl_defs;

   typedef enum logic [1:0] {
      FLOW_L   = 2'd0,
      FLOW_R   = 2'd1,
      PINGPONG = 2'd2,
      BLINK    = 2'd3
   } mode_e;

   // led_out is active-low: a 0 bit lights the LED
   localparam logic [7:0] LED_START_L = 8'hFE;
   localparam logic [7:0] LED_START_R = 8'h7F;
   localparam logic [7:0] LED_ALL_ON  = 8'h00;
   localparam logic [7:0] LED_ALL_OFF = 8'hFF;

   localparam logic [2:0] POS_MIN = 3'd0;
   localparam logic [2:0] POS_MAX = 3'd7;

   function automatic logic [7:0] led_onehot(
      input logic [2:0] pos
   );
      return ~(8'h01 << pos);
   endfunction

   function automatic mode_e next_mode(
      input mode_e m
   );
      mode_e r;
      unique case (m)
         FLOW_L:   r = FLOW_R;
         FLOW_R:   r = PINGPONG;
         PINGPONG: r = BLINK;
         BLINK:    r = FLOW_L;
         default:  r = FLOW_L;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/led_seq_ctrl_if.sv
// led_seq_ctrl_if: board-side signals of the LED sequencer.
// key_in (raw keys, active-low), led_out, mode_out, run_out.
interface led_seq_ctrl_if;
   import led_ctrl_defs::*;

   logic [1:0] key_in;
   logic [7:0] led_out;
   mode_e      mode_out;
   logic       run_out;

   modport master (
      output key_in,
      input  led_out,
      input  mode_out,
      input  run_out
   );

   modport slave (
      input  key_in,
      output led_out,
      output mode_out,
      output run_out
   );

endinterface

// File: rtl/led_seq_ctrl_key_filter.sv
// key_filter: 2-flop synchroniser, stable-low counter and
// one-shot press flag. Ports: sys_clk, sys_rst_n, key_i, flag_o.
module key_filter #(
   parameter logic [19:0] DEB_MAX = 20'd999_999
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic key_i,
   output logic flag_o
);

   logic        sync1_q;
   logic        sync2_q;
   logic [19:0] cnt_q;
   logic [19:0] cnt_d;
   logic        flag_q;
   logic        flag_d;

   always_comb begin
      cnt_d  = cnt_q;
      flag_d = 1'b0;
      if (sync2_q) begin
         cnt_d = '0;
      end else if (cnt_q != DEB_MAX) begin
         cnt_d = cnt_q + 20'd1;
      end
      // fire only on the step into DEB_MAX, so a held key
      // sitting at saturation never retriggers
      flag_d = !sync2_q &&
               (cnt_d == DEB_MAX) &&
               (cnt_q != DEB_MAX);
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         cnt_q   <= '0;
         flag_q  <= 1'b0;
      end else begin
         sync1_q <= key_i;
         sync2_q <= sync1_q;
         cnt_q   <= cnt_d;
         flag_q  <= flag_d;
      end
   end

   assign flag_o = flag_q;

endmodule

// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: steps one of four LED patterns on a tick.
// Ports: sys_clk, sys_rst_n, bus (key_in/led_out/mode_out/run_out).
module led_seq_ctrl
   import led_ctrl_defs::*;
#(
   parameter logic [26:0] CNT_MAX = 27'd49_999_999,
   parameter logic [19:0] DEB_MAX = 20'd999_999
) (
   input  logic           sys_clk,
   input  logic           sys_rst_n,
   led_seq_ctrl_if.slave  bus
);

   logic        mode_flag;
   logic        run_flag;

   logic [26:0] tick_q;
   logic [26:0] tick_d;
   mode_e       mode_q;
   mode_e       mode_d;
   logic        run_q;
   logic        run_d;
   logic [2:0]  pos_q;
   logic [2:0]  pos_d;
   logic        dir_q;
   logic        dir_d;
   logic        phase_q;
   logic        phase_d;
   logic [7:0]  led_q;
   logic [7:0]  led_d;

   logic        step;
   logic        advance;

   key_filter #(
      .DEB_MAX (DEB_MAX)
   ) u_key_mode (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .key_i     (bus.key_in[0]),
      .flag_o    (mode_flag)
   );

   key_filter #(
      .DEB_MAX (DEB_MAX)
   ) u_key_run (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .key_i     (bus.key_in[1]),
      .flag_o    (run_flag)
   );

   assign step = run_q && (tick_q == CNT_MAX);

   // any key event discards a coinciding step: a mode press
   // loads the new start state, a pause press freezes
   assign advance = step && !mode_flag && !run_flag;

   always_comb begin
      tick_d  = tick_q + 27'd1;
      mode_d  = mode_q;
      run_d   = run_q;
      pos_d   = pos_q;
      dir_d   = dir_q;
      phase_d = phase_q;
      led_d   = led_q;

      if (mode_flag || run_flag || !run_q || step) begin
         tick_d = '0;
      end

      if (run_flag) begin
         run_d = ~run_q;
      end

      unique case (1'b1)
         mode_flag: begin
            mode_d  = next_mode(mode_q);
            pos_d   = POS_MIN;
            dir_d   = 1'b1;
            phase_d = 1'b0;
            unique case (mode_d)
               FLOW_L:   led_d = LED_START_L;
               FLOW_R: begin
                  pos_d = POS_MAX;
                  led_d = LED_START_R;
               end
               PINGPONG: led_d = LED_START_L;
               BLINK:    led_d = LED_ALL_ON;
               default:  led_d = LED_START_L;
            endcase
         end
         advance: begin
            unique case (mode_q)
               FLOW_L: begin
                  pos_d = pos_q + 3'd1;
                  led_d = led_onehot(pos_d);
               end
               FLOW_R: begin
                  pos_d = pos_q - 3'd1;
                  led_d = led_onehot(pos_d);
               end
               PINGPONG: begin
                  // turn around without repeating the end LED
                  if (dir_q && pos_q == POS_MAX) begin
                     dir_d = 1'b0;
                     pos_d = POS_MAX - 3'd1;
                  end else if (!dir_q && pos_q == POS_MIN) begin
                     dir_d = 1'b1;
                     pos_d = POS_MIN + 3'd1;
                  end else if (dir_q) begin
                     pos_d = pos_q + 3'd1;
                  end else begin
                     pos_d = pos_q - 3'd1;
                  end
                  led_d = led_onehot(pos_d);
               end
               BLINK: begin
                  phase_d = ~phase_q;
                  led_d   = phase_d ? LED_ALL_OFF : LED_ALL_ON;
               end
               default: led_d = led_q;
            endcase
         end
         default: ;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         tick_q  <= '0;
         mode_q  <= FLOW_L;
         run_q   <= 1'b1;
         pos_q   <= POS_MIN;
         dir_q   <= 1'b1;
         phase_q <= 1'b0;
         led_q   <= LED_START_L;
      end else begin
         tick_q  <= tick_d;
         mode_q  <= mode_d;
         run_q   <= run_d;
         pos_q   <= pos_d;
         dir_q   <= dir_d;
         phase_q <= phase_d;
         led_q   <= led_d;
      end
   end

   assign bus.led_out  = led_q;
   assign bus.mode_out = mode_q;
   assign bus.run_out  = run_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb_led_seq_ctrl: directed bench for led_seq_ctrl with
// CNT_MAX=24, DEB_MAX=4 and a 10 ns clock.
module tb_led_seq_ctrl;
   import led_ctrl_defs::*;

   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   led_seq_ctrl_if bus ();

   led_seq_ctrl #(
      .CNT_MAX (27'd24),
      .DEB_MAX (20'd4)
   ) dut (
      .sys_clk   (clk),
      .sys_rst_n (rst_n),
      .bus       (bus)
   );

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.key_in = 2'b11;
      #12;
      total++;
      if (bus.led_out !== LED_START_L) begin
         bad++;
         $display("FAIL reset_led got=%h exp=%h", bus.led_out, LED_START_L);
      end
      total++;
      if (bus.mode_out !== FLOW_L) begin
         bad++;
         $display("FAIL reset_mode got=%0d exp=0", bus.mode_out);
      end
      total++;
      if (bus.run_out !== 1'b1) begin
         bad++;
         $display("FAIL reset_run got=%b exp=1", bus.run_out);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_flow_l();
      logic [7:0] exp [8];
      logic [7:0] prev;
      exp = '{8'hFD, 8'hFB, 8'hF7, 8'hEF,
              8'hDF, 8'hBF, 8'h7F, 8'hFE};
      prev = 8'hFE;
      for (int s = 0; s < 8; s++) begin
         cyc(24);
         total++;
         if (bus.led_out !== prev) begin
            bad++;
            $display("FAIL flowl_hold%0d got=%h exp=%h", s, bus.led_out, prev);
         end
         cyc(1);
         total++;
         if (bus.led_out !== exp[s]) begin
            bad++;
            $display("FAIL flowl_step%0d got=%h exp=%h", s, bus.led_out, exp[s]);
         end
         total++;
         if (bus.mode_out !== FLOW_L || bus.run_out !== 1'b1) begin
            bad++;
            $display("FAIL flowl_mr%0d got=%0d/%b exp=0/1", s, bus.mode_out, bus.run_out);
         end
         prev = exp[s];
      end
   endtask

   task automatic test_mode_walk();
      bus.key_in[0] = 1'b0;
      cyc(6);
      total++;
      if (bus.mode_out !== FLOW_L) begin
         bad++;
         $display("FAIL walk_early got=%0d exp=0", bus.mode_out);
      end
      cyc(1);
      total++;
      if (bus.mode_out !== FLOW_R || bus.led_out !== LED_START_R) begin
         bad++;
         $display("FAIL walk_load got=%0d/%h exp=1/7f", bus.mode_out, bus.led_out);
      end
      cyc(13);
      total++;
      if (bus.mode_out !== FLOW_R) begin
         bad++;
         $display("FAIL walk_held got=%0d exp=1", bus.mode_out);
      end
      bus.key_in[0] = 1'b1;
      cyc(10);
   endtask

   task automatic test_pingpong();
      int pos [16];
      logic [7:0] e;
      pos = '{1, 2, 3, 4, 5, 6, 7, 6,
              5, 4, 3, 2, 1, 0, 1, 2};
      bus.key_in[0] = 1'b0;
      cyc(7);
      total++;
      if (bus.mode_out !== PINGPONG || bus.led_out !== 8'hFE) begin
         bad++;
         $display("FAIL pp_load got=%0d/%h exp=2/fe", bus.mode_out, bus.led_out);
      end
      bus.key_in[0] = 1'b1;
      for (int s = 0; s < 16; s++) begin
         cyc(25);
         e = ~(8'h01 << pos[s]);
         total++;
         if (bus.led_out !== e) begin
            bad++;
            $display("FAIL pp_step%0d got=%h exp=%h", s, bus.led_out, e);
         end
      end
   endtask

   task automatic test_blink();
      bus.key_in[0] = 1'b0;
      cyc(7);
      total++;
      if (bus.mode_out !== BLINK || bus.led_out !== 8'h00) begin
         bad++;
         $display("FAIL blink_load got=%0d/%h exp=3/00", bus.mode_out, bus.led_out);
      end
      bus.key_in[0] = 1'b1;
      cyc(24);
      total++;
      if (bus.led_out !== 8'h00) begin
         bad++;
         $display("FAIL blink_hold got=%h exp=00", bus.led_out);
      end
      cyc(1);
      total++;
      if (bus.led_out !== 8'hFF) begin
         bad++;
         $display("FAIL blink_p1 got=%h exp=ff", bus.led_out);
      end
      cyc(25);
      total++;
      if (bus.led_out !== 8'h00) begin
         bad++;
         $display("FAIL blink_p0 got=%h exp=00", bus.led_out);
      end
      cyc(25);
      total++;
      if (bus.led_out !== 8'hFF) begin
         bad++;
         $display("FAIL blink_p1b got=%h exp=ff", bus.led_out);
      end
   endtask

   task automatic test_bounce();
      for (int b = 0; b < 5; b++) begin
         bus.key_in[0] = 1'b0;
         cyc(3);
         bus.key_in[0] = 1'b1;
         cyc(1);
         total++;
         if (bus.mode_out !== BLINK) begin
            bad++;
            $display("FAIL bounce%0d got=%0d exp=3", b, bus.mode_out);
         end
      end
      bus.key_in[0] = 1'b0;
      cyc(6);
      bus.key_in[0] = 1'b1;
      cyc(2);
      total++;
      if (bus.mode_out !== FLOW_L || bus.led_out !== 8'hFE) begin
         bad++;
         $display("FAIL bounce_hold got=%0d/%h exp=0/fe", bus.mode_out, bus.led_out);
      end
      cyc(10);
      total++;
      if (bus.mode_out !== FLOW_L) begin
         bad++;
         $display("FAIL bounce_once got=%0d exp=0", bus.mode_out);
      end
   endtask

   task automatic test_pause();
      bus.key_in[1] = 1'b0;
      cyc(7);
      total++;
      if (bus.run_out !== 1'b0 || bus.led_out !== 8'hFE) begin
         bad++;
         $display("FAIL pause_set got=%b/%h exp=0/fe", bus.run_out, bus.led_out);
      end
      bus.key_in[1] = 1'b1;
      for (int c = 0; c < 200; c++) begin
         cyc(1);
         total++;
         if (bus.led_out !== 8'hFE || bus.run_out !== 1'b0) begin
            bad++;
            $display("FAIL pause_frozen%0d got=%h/%b exp=fe/0", c, bus.led_out, bus.run_out);
         end
      end
      bus.key_in[1] = 1'b0;
      cyc(7);
      total++;
      if (bus.run_out !== 1'b1 || bus.mode_out !== FLOW_L) begin
         bad++;
         $display("FAIL resume got=%b/%0d exp=1/0", bus.run_out, bus.mode_out);
      end
      bus.key_in[1] = 1'b1;
      cyc(24);
      total++;
      if (bus.led_out !== 8'hFE) begin
         bad++;
         $display("FAIL resume_hold got=%h exp=fe", bus.led_out);
      end
      cyc(1);
      total++;
      if (bus.led_out !== 8'hFD) begin
         bad++;
         $display("FAIL resume_step got=%h exp=fd", bus.led_out);
      end
   endtask

   task automatic test_collision();
      cyc(18);
      bus.key_in[0] = 1'b0;
      cyc(7);
      total++;
      if (bus.mode_out !== FLOW_R || bus.led_out !== 8'h7F) begin
         bad++;
         $display("FAIL coll_load got=%0d/%h exp=1/7f", bus.mode_out, bus.led_out);
      end
      bus.key_in[0] = 1'b1;
      cyc(24);
      total++;
      if (bus.led_out !== 8'h7F) begin
         bad++;
         $display("FAIL coll_hold got=%h exp=7f", bus.led_out);
      end
      cyc(1);
      total++;
      if (bus.led_out !== 8'hBF) begin
         bad++;
         $display("FAIL coll_step got=%h exp=bf", bus.led_out);
      end
   endtask

   task automatic test_both_keys();
      bus.key_in = 2'b00;
      cyc(7);
      total++;
      if (bus.mode_out !== PINGPONG || bus.run_out !== 1'b0 ||
          bus.led_out !== 8'hFE) begin
         bad++;
         $display("FAIL both got=%0d/%b/%h exp=2/0/fe", bus.mode_out, bus.run_out, bus.led_out);
      end
      bus.key_in = 2'b11;
      cyc(5);
   endtask

   task automatic test_midreset();
      bus.key_in[1] = 1'b0;
      cyc(7);
      bus.key_in[1] = 1'b1;
      total++;
      if (bus.run_out !== 1'b1) begin
         bad++;
         $display("FAIL mr_resume got=%b exp=1", bus.run_out);
      end
      cyc(25);
      total++;
      if (bus.led_out !== 8'hFD) begin
         bad++;
         $display("FAIL mr_prestep got=%h exp=fd", bus.led_out);
      end
      bus.key_in[0] = 1'b0;
      cyc(3);
      rst_n = 1'b0;
      #2;
      total++;
      if (bus.led_out !== 8'hFE || bus.mode_out !== FLOW_L ||
          bus.run_out !== 1'b1) begin
         bad++;
         $display("FAIL mr_async got=%h/%0d/%b exp=fe/0/1", bus.led_out, bus.mode_out, bus.run_out);
      end
      bus.key_in[0] = 1'b1;
      cyc(3);
      rst_n = 1'b1;
      cyc(20);
      total++;
      if (bus.mode_out !== FLOW_L || bus.run_out !== 1'b1 ||
          bus.led_out !== 8'hFE) begin
         bad++;
         $display("FAIL mr_noflag got=%0d/%b/%h exp=0/1/fe", bus.mode_out, bus.run_out, bus.led_out);
      end
      cyc(5);
      total++;
      if (bus.led_out !== 8'hFD) begin
         bad++;
         $display("FAIL mr_step got=%h exp=fd", bus.led_out);
      end
   endtask

   initial begin
      test_reset();
      test_flow_l();
      test_mode_walk();
      test_pingpong();
      test_blink();
      test_bounce();
      test_pause();
      test_collision();
      test_both_keys();
      test_midreset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/led_seq_ctrl.md
# led_seq_ctrl

Sequencing controller for the 8-LED bank on the board. It generates its own step tick from a parameterised cycle counter and steps one of four display patterns (flow left, flow right, ping-pong, blink) on `led_out`. Two board keys, each debounced internally, select the pattern and pause or resume it. It replaces direct top-level drive of `led_out` by a single fixed-pattern block.

## Interface
- `CNT_MAX`, 27'd49_999_999: step period minus one, in `sys_clk` cycles. The default gives 0.5 s at 100 MHz.
- `DEB_MAX`, 20'd999_999: debounce stable-low count. The default gives 10 ms at 100 MHz.

- `sys_clk`  in  1  system clock. Single clock domain.
- `sys_rst_n`  in  1  reset, asynchronous, active-low.
- `key_in`  in  2  raw board keys, active-low and asynchronous. `key_in[0]` = next mode; `key_in[1]` = pause/run toggle.
- `led_out`  out  8  LED drive, active-low. A 0 bit means the LED is lit.
- `mode_out`  out  2  current mode: 0 FLOW_L, 1 FLOW_R, 2 PINGPONG, 3 BLINK.
- `run_out`  out  1  1 = sequencing, 0 = paused.

## Operation
- **Reset values**
  - `led_out` = 8'hFE (LED0 lit).
  - `mode_out` = 0; `run_out` = 1.
  - Tick counter = 0; position = 0; direction = up; blink phase = 0.
- **Tick counter**
  - Counts 0..`CNT_MAX` while running.
  - A step occurs on the edge where the counter = `CNT_MAX`; the counter wraps to 0 on that edge.
  - While paused, the counter is held at 0.
- **FLOW_L:** one lit LED; position 0→1→…→7→0.
- **FLOW_R:** one lit LED; position 7→6→…→0→7.
- **PINGPONG:** one lit LED, bouncing.
  - Sequence 0,1,…,7,6,…,1,0,1,…; end LEDs are never repeated.
  - At position 7 going up: direction flips and the next position is 6.
  - At position 0 going down: direction flips and the next position is 1.
- **BLINK:** phase 0 shows 8'h00 (all lit); phase 1 shows 8'hFF (all off). The phase toggles on each step.
- **Mode select (`key_in[0]` debounced press):**
  - Mode advances 0→1→2→3→0.
  - Tick counter clears to 0.
  - The pattern loads the new mode's start state:
    - FLOW_L: position 0, `led_out` 8'hFE.
    - FLOW_R: position 7, `led_out` 8'h7F.
    - PINGPONG: position 0, direction up, `led_out` 8'hFE.
    - BLINK: phase 0, `led_out` 8'h00.
  - `run_out` is unchanged by a mode change.
- **Pause toggle (`key_in[1]` debounced press):**
  - Toggles `run_out`.
  - The pattern freezes at its current value.
  - The tick counter clears.
- **Simultaneous events:**
  - A mode press in the same cycle as a step: the mode load wins and the step is discarded.
  - Both key flags in the same cycle: both take effect, and the load is a mode load.
- **Debounce (per key):**
  - 2-flop synchroniser, then a stable counter.
  - The counter increments each cycle the synchronised key is low and saturates at `DEB_MAX`.
  - Any high sample clears it to 0.
  - A registered one-cycle flag fires on the edge where the count reaches `DEB_MAX`.
  - Exactly one flag per press; holding the key never repeats it.
- **Reset mid-operation:** asynchronous assertion immediately forces all reset values, including debounce state.

## Timing
- Let edge E0 be the first `sys_clk` edge that samples `key_in[i]` low, with the key held low afterwards.
  - The debounce flag is high in the cycle after edge E(`DEB_MAX`+1).
  - `mode_out` / `run_out` / `led_out` update at edge E(`DEB_MAX`+2).
- After reset release, a mode load, or a resume, the first step lands `CNT_MAX`+1 cycles later. Subsequent steps occur every `CNT_MAX`+1 cycles.
- All outputs are registered directly from flops; there is no combinational path from `key_in`.

## Structure
- Put the mode encodings (FLOW_L/FLOW_R/PINGPONG/BLINK) and the start patterns 8'hFE / 8'h7F / 8'h00 in a shared include/package, `led_ctrl_defs`. The bench also uses it.
- One sub-module, `key_filter`: synchroniser, stable counter and one-shot flag, parameterised by `DEB_MAX`. It is instantiated twice.
- The top level holds the tick counter, mode/run registers, position/direction/phase registers and the `led_out` register.

## Test plan
All scenarios use `CNT_MAX`=24 and `DEB_MAX`=4 with a 10 ns clock.

1. **Reset release, keys idle:** `led_out` steps FE→FD→FB→…→7F→FE, one step per 25 cycles; `mode_out`=0 and `run_out`=1 throughout.
2. **Mode walk:** hold `key_in[0]` low from E0 for 20 cycles → `mode_out`=1 and `led_out`=7F at E6. Repeat twice more → mode 2, then 3 (`led_out`=00), with no extra increments while the key is held.
3. **PINGPONG:** observe 16 steps → bit positions 0..7..1,0 with no repeat at 7 or 0.
4. **Bounce rejection:** `key_in[0]` toggles low 3 cycles, high 1 cycle, repeatedly → `mode_out` never changes. Then hold it low 6 cycles → exactly one increment.
5. **Pause and collision:**
   - Press `key_in[1]` → `run_out`=0 and `led_out` frozen for 200 cycles.
   - Press again → first step exactly 25 cycles after resume.
   - Time a mode flag to coincide with a step → only the mode load is visible.
6. **Mid-run reset:** assert `sys_rst_n` low mid-pattern and mid-debounce → outputs become FE / 0 / 1 immediately, and no flag follows release.
